// File: rtl/ctrl_pkg.sv
// ctrl_pkg -- shared definitions for the ID-stage control/issue block.
//   Opcode constants, ALUop encodings, FSM state constants, the JM_WAIT length
//   and the packed control bundle that travels to ID/EX.
package ctrl_pkg;

  // Opcodes
  localparam logic [3:0] OpNop  = 4'b0000;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpAdd  = 4'b0100;
  localparam logic [3:0] OpInc  = 4'b0101;
  localparam logic [3:0] OpNeg  = 4'b0110;
  localparam logic [3:0] OpSub  = 4'b0111;
  localparam logic [3:0] OpJ    = 4'b1000;
  localparam logic [3:0] OpBrz  = 4'b1001;
  localparam logic [3:0] OpJm   = 4'b1010;
  localparam logic [3:0] OpBrn  = 4'b1011;
  localparam logic [3:0] OpLd   = 4'b1110;
  localparam logic [3:0] OpSvpc = 4'b1111;

  // ALUop encodings
  localparam logic [1:0] AluAdd = 2'b00;
  localparam logic [1:0] AluInc = 2'b01;
  localparam logic [1:0] AluNeg = 2'b10;
  localparam logic [1:0] AluSub = 2'b11;

  // FSM states
  typedef logic [1:0] state_t;
  localparam state_t StRun     = 2'd0;
  localparam state_t StLuStall = 2'd1;
  localparam state_t StJmWait  = 2'd2;
  localparam state_t StFlush   = 2'd3;

  // Number of bubble cycles after a JM issues
  localparam logic [1:0] JmWaitLen = 2'd2;

  typedef struct packed {
    logic       regWrt;
    logic       memtoReg;
    logic       pcToReg;
    logic       branchN;
    logic       branchZ;
    logic       jump;
    logic       jumpMem;
    logic       memRead;
    logic       memWrite;
    logic [1:0] aluOp;
  } ctrl_t;

  localparam int unsigned CtrlWidth = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode -- pure combinational opcode-to-control-bundle table.
//   opcode in  4          instruction opcode
//   ctrl   out CtrlWidth  packed ctrl_t bundle (unused opcodes decode as NOP)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [3:0]           opcode,
  output logic [CtrlWidth-1:0] ctrl
);

  ctrl_t dec;

  always_comb begin
    dec = '0;
    case (opcode)
      OpSvpc: begin
        dec.regWrt  = 1'b1;
        dec.pcToReg = 1'b1;
      end
      OpLd: begin
        dec.regWrt   = 1'b1;
        dec.memtoReg = 1'b1;
        dec.memRead  = 1'b1;
      end
      OpSt:  dec.memWrite = 1'b1;
      OpAdd: begin
        dec.regWrt = 1'b1;
        dec.aluOp  = AluAdd;
      end
      OpInc: begin
        dec.regWrt = 1'b1;
        dec.aluOp  = AluInc;
      end
      OpNeg: begin
        dec.regWrt = 1'b1;
        dec.aluOp  = AluNeg;
      end
      OpSub: begin
        dec.regWrt = 1'b1;
        dec.aluOp  = AluSub;
      end
      OpJ:   dec.jump    = 1'b1;
      OpBrz: dec.branchZ = 1'b1;
      OpJm: begin
        dec.jumpMem = 1'b1;
        dec.memRead = 1'b1;
      end
      OpBrn: dec.branchN = 1'b1;
      default: dec = '0;
    endcase
  end

  assign ctrl = dec;

endmodule

// File: rtl/id_ctrl_issue.sv
// id_ctrl_issue -- ID-stage control issue: decodes the IF/ID instruction into
// the ID/EX control bundle and sequences bubbles, stalls and flushes for
// load-use hazards, JM (jump-through-memory) and taken branches.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   instr_valid, opcode         IF/ID instruction
//   id_rs, id_rt                IF/ID source register fields
//   ex_memRead, ex_rd           load-in-EX indication and its destination
//   branch_taken                EX resolved a taken BRZ/BRN/J
//   RegWrt..memWrite, ALUop     control bundle to ID/EX
//   pc_stall, ifid_stall        hold PC / hold IF/ID
//   ifid_flush                  invalidate IF/ID
//
// Configuration
//   ISSUE_HAZARD_STALL_EN  defined: load-use detection and LU_STALL enabled.
//                          undefined: no load-use check; software inserts NOPs.
module id_ctrl_issue
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  input  logic [3:0] opcode,
  input  logic [5:0] id_rs,
  input  logic [5:0] id_rt,
  input  logic       ex_memRead,
  input  logic [5:0] ex_rd,
  input  logic       branch_taken,
  output logic       RegWrt,
  output logic       MemtoReg,
  output logic       PCtoReg,
  output logic       BranchN,
  output logic       BranchZ,
  output logic       Jump,
  output logic       JumpMem,
  output logic       memRead,
  output logic       memWrite,
  output logic [1:0] ALUop,
  output logic       pc_stall,
  output logic       ifid_stall,
  output logic       ifid_flush
);

  state_t     stateQ, stateD;
  logic [1:0] cntQ, cntD;

  logic [CtrlWidth-1:0] decodedBits;
  ctrl_t                decoded;
  ctrl_t                ctrlOut;
  logic                 luHazard;

  ctrl_decode uDecode (
    .opcode (opcode),
    .ctrl   (decodedBits)
  );

  assign decoded = ctrl_t'(decodedBits);

`ifdef ISSUE_HAZARD_STALL_EN
  // r0 is hard-wired zero, so a load into it never creates a dependency.
  assign luHazard = ex_memRead && (ex_rd != 6'd0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
`else
  logic unusedHazardIns;
  assign unusedHazardIns = ^{ex_memRead, ex_rd, id_rs, id_rt};
  assign luHazard        = 1'b0;
`endif

  always_comb begin
    ctrlOut    = '0;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    stateD     = stateQ;
    cntD       = cntQ;

    if (!rst_n) begin
      // Outputs held at zero for the whole reset, independent of the inputs.
      stateD = StRun;
      cntD   = '0;
    end else if (branch_taken) begin
      // A taken branch squashes whatever is in progress, including JM_WAIT.
      ifid_flush = 1'b1;
      stateD     = StFlush;
      cntD       = '0;
    end else begin
      case (stateQ)
        StRun: begin
          if (instr_valid) begin
            if (luHazard) begin
              pc_stall   = 1'b1;
              ifid_stall = 1'b1;
              stateD     = StLuStall;
            end else begin
              ctrlOut = decoded;
              if (decoded.jumpMem) begin
                stateD = StJmWait;
                cntD   = JmWaitLen;
              end
            end
          end
        end
        StLuStall: begin
          // Keep the dependent instruction held in IF/ID so it reissues in RUN.
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          stateD     = StRun;
        end
        StJmWait: begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
          if (cntQ != 2'd0) begin
            cntD = 2'(cntQ - 2'd1);
          end
          if (cntQ <= 2'd1) begin
            stateD = StRun;
          end
        end
        StFlush: begin
          ifid_flush = 1'b1;
          stateD     = StRun;
        end
        default: begin
          stateD = StRun;
          cntD   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= StRun;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  assign RegWrt   = ctrlOut.regWrt;
  assign MemtoReg = ctrlOut.memtoReg;
  assign PCtoReg  = ctrlOut.pcToReg;
  assign BranchN  = ctrlOut.branchN;
  assign BranchZ  = ctrlOut.branchZ;
  assign Jump     = ctrlOut.jump;
  assign JumpMem  = ctrlOut.jumpMem;
  assign memRead  = ctrlOut.memRead;
  assign memWrite = ctrlOut.memWrite;
  assign ALUop    = ctrlOut.aluOp;

endmodule
